// File: rtl/eva_axi_pkg.sv
// Shared widths, AR state encoding and the outstanding-burst counter update
// for the two-master AXI read arbiter.
package eva_axi_pkg;

    localparam int ID_W    = 4;
    localparam int DATA_W  = 128;
    localparam int LEN_W   = 6;
    localparam int ADDR_W  = 32;
    localparam int SIZE_W  = 3;
    localparam int BURST_W = 2;
    localparam int RESP_W  = 2;
    localparam int OUTST_W = 3;

    typedef enum logic {
        AR_IDLE  = 1'b0,
        AR_ISSUE = 1'b1
    } ar_state_t;

    // Simultaneous issue and retire cancel out; a retire at zero is an orphan
    // and must leave the count at zero.
    function automatic logic [OUTST_W-1:0] outst_next(
        input logic [OUTST_W-1:0] cur,
        input logic               inc,
        input logic               dec
    );
        logic [OUTST_W-1:0] nxt;
        nxt = cur;
        if (inc && !dec) begin
            nxt = cur + OUTST_W'(1);
        end else if (dec && !inc && (cur != '0)) begin
            nxt = cur - OUTST_W'(1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/eva_rr_arb2.sv
// Two-way round-robin picker: the requester not granted last wins a tie,
// a lone requester always wins. Pointer moves only when a grant is made.
module eva_rr_arb2 (
    input  logic       aclk,
    input  logic       arest_n,
    input  logic [1:0] i_req,
    input  logic       i_en,
    output logic [1:0] o_gnt,
    output logic       o_last
);

    logic r_last;

    always_comb begin
        o_gnt = 2'b00;
        if (i_en) begin
            case (i_req)
                2'b01:   o_gnt = 2'b01;
                2'b10:   o_gnt = 2'b10;
                2'b11:   o_gnt = r_last ? 2'b01 : 2'b10;
                default: o_gnt = 2'b00;
            endcase
        end
    end

    // Reset value 1 makes master 0 the winner of the first tie.
    always_ff @(posedge aclk or negedge arest_n) begin
        if (!arest_n) begin
            r_last <= 1'b1;
        end else if (i_en && (i_req != 2'b00)) begin
            r_last <= o_gnt[1];
        end
    end

    assign o_last = r_last;

endmodule

// File: rtl/eva_axi_rd_arb.sv
// Two-master to one-slave AXI read arbiter: round-robin AR issue with a
// per-master outstanding-burst limit, and zero-latency R routing by s_rid[3].
module eva_axi_rd_arb
    import eva_axi_pkg::*;
#(
    parameter int MAX_OUTST = 4
) (
    input  logic                 aclk,
    input  logic                 arest_n,

    input  logic                 m0_arvalid,
    output logic                 m0_arready,
    input  logic [ID_W-2:0]      m0_arid,
    input  logic [ADDR_W-1:0]    m0_araddr,
    input  logic [LEN_W-1:0]     m0_arlen,
    input  logic [SIZE_W-1:0]    m0_arsize,
    input  logic [BURST_W-1:0]   m0_arburst,
    output logic                 m0_rvalid,
    output logic                 m0_rlast,
    output logic [ID_W-2:0]      m0_rid,
    output logic [DATA_W-1:0]    m0_rdata,
    output logic [RESP_W-1:0]    m0_rresp,
    input  logic                 m0_rready,

    input  logic                 m1_arvalid,
    output logic                 m1_arready,
    input  logic [ID_W-2:0]      m1_arid,
    input  logic [ADDR_W-1:0]    m1_araddr,
    input  logic [LEN_W-1:0]     m1_arlen,
    input  logic [SIZE_W-1:0]    m1_arsize,
    input  logic [BURST_W-1:0]   m1_arburst,
    output logic                 m1_rvalid,
    output logic                 m1_rlast,
    output logic [ID_W-2:0]      m1_rid,
    output logic [DATA_W-1:0]    m1_rdata,
    output logic [RESP_W-1:0]    m1_rresp,
    input  logic                 m1_rready,

    output logic                 s_arvalid,
    input  logic                 s_arready,
    output logic [ID_W-1:0]      s_arid,
    output logic [ADDR_W-1:0]    s_araddr,
    output logic [LEN_W-1:0]     s_arlen,
    output logic [SIZE_W-1:0]    s_arsize,
    output logic [BURST_W-1:0]   s_arburst,

    input  logic                 s_rvalid,
    output logic                 s_rready,
    input  logic                 s_rlast,
    input  logic [ID_W-1:0]      s_rid,
    input  logic [DATA_W-1:0]    s_rdata,
    input  logic [RESP_W-1:0]    s_rresp,

    output logic                 err_orphan,

    output logic                 dbg_ar_state,
    output logic                 dbg_last_gnt,
    output logic [OUTST_W-1:0]   dbg_outst0,
    output logic [OUTST_W-1:0]   dbg_outst1
);

    // Handshakes: a transfer happens on a rising edge where valid and ready
    // are both 1; valid never waits on ready, and s_ar* hold while unaccepted.

    localparam logic [OUTST_W-1:0] OUTST_LIMIT = OUTST_W'(MAX_OUTST);

    ar_state_t            r_state;
    ar_state_t            w_state_next;
    logic                 w_grant;

    logic                 w_elig0;
    logic                 w_elig1;
    logic                 w_arb_en;
    logic [1:0]           w_gnt;
    logic                 w_last_gnt;

    logic [ID_W-1:0]      r_s_arid;
    logic [ADDR_W-1:0]    r_s_araddr;
    logic [LEN_W-1:0]     r_s_arlen;
    logic [SIZE_W-1:0]    r_s_arsize;
    logic [BURST_W-1:0]   r_s_arburst;

    logic [OUTST_W-1:0]   r_outst0;
    logic [OUTST_W-1:0]   r_outst1;
    logic                 r_err_orphan;
    logic                 w_r_last_hs;
    logic                 w_dec0;
    logic                 w_dec1;
    logic                 w_orphan;

    assign w_elig0  = m0_arvalid && (r_outst0 < OUTST_LIMIT);
    assign w_elig1  = m1_arvalid && (r_outst1 < OUTST_LIMIT);
    // Holding the arbiter off during reset keeps arready low while reset is low.
    assign w_arb_en = (r_state == AR_IDLE) && arest_n;

    eva_rr_arb2 u_rr_arb2 (
        .aclk    (aclk),
        .arest_n (arest_n),
        .i_req   ({w_elig1, w_elig0}),
        .i_en    (w_arb_en),
        .o_gnt   (w_gnt),
        .o_last  (w_last_gnt)
    );

    assign m0_arready = w_gnt[0];
    assign m1_arready = w_gnt[1];

    always_ff @(posedge aclk or negedge arest_n) begin
        if (!arest_n) begin
            r_state <= AR_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_grant      = 1'b0;
        case (r_state)
            AR_IDLE: begin
                if (w_gnt != 2'b00) begin
                    w_grant      = 1'b1;
                    w_state_next = AR_ISSUE;
                end
            end
            AR_ISSUE: begin
                if (s_arready) begin
                    w_state_next = AR_IDLE;
                end
            end
            default: begin
                w_state_next = AR_IDLE;
            end
        endcase
    end

    // Payload is captured only on a grant so it stays frozen through ISSUE.
    always_ff @(posedge aclk or negedge arest_n) begin
        if (!arest_n) begin
            r_s_arid    <= '0;
            r_s_araddr  <= '0;
            r_s_arlen   <= '0;
            r_s_arsize  <= '0;
            r_s_arburst <= '0;
        end else if (w_grant) begin
            if (w_gnt[1]) begin
                r_s_arid    <= {1'b1, m1_arid};
                r_s_araddr  <= m1_araddr;
                r_s_arlen   <= m1_arlen;
                r_s_arsize  <= m1_arsize;
                r_s_arburst <= m1_arburst;
            end else begin
                r_s_arid    <= {1'b0, m0_arid};
                r_s_araddr  <= m0_araddr;
                r_s_arlen   <= m0_arlen;
                r_s_arsize  <= m0_arsize;
                r_s_arburst <= m0_arburst;
            end
        end
    end

    // Valid comes straight from the state register so reset drops it at once.
    assign s_arvalid = (r_state == AR_ISSUE);
    assign s_arid    = r_s_arid;
    assign s_araddr  = r_s_araddr;
    assign s_arlen   = r_s_arlen;
    assign s_arsize  = r_s_arsize;
    assign s_arburst = r_s_arburst;

    assign s_rready  = s_rid[ID_W-1] ? m1_rready : m0_rready;
    assign m0_rvalid = s_rvalid && !s_rid[ID_W-1];
    assign m1_rvalid = s_rvalid &&  s_rid[ID_W-1];
    assign m0_rid    = s_rid[ID_W-2:0];
    assign m1_rid    = s_rid[ID_W-2:0];
    assign m0_rdata  = s_rdata;
    assign m1_rdata  = s_rdata;
    assign m0_rresp  = s_rresp;
    assign m1_rresp  = s_rresp;
    assign m0_rlast  = s_rlast;
    assign m1_rlast  = s_rlast;

    assign w_r_last_hs = s_rvalid && s_rready && s_rlast;
    assign w_dec0      = w_r_last_hs && !s_rid[ID_W-1];
    assign w_dec1      = w_r_last_hs &&  s_rid[ID_W-1];
    assign w_orphan    = (w_dec0 && (r_outst0 == '0)) || (w_dec1 && (r_outst1 == '0));

    always_ff @(posedge aclk or negedge arest_n) begin
        if (!arest_n) begin
            r_outst0     <= '0;
            r_outst1     <= '0;
            r_err_orphan <= 1'b0;
        end else begin
            r_outst0 <= outst_next(r_outst0, m0_arready, w_dec0);
            r_outst1 <= outst_next(r_outst1, m1_arready, w_dec1);
            if (w_orphan) begin
                r_err_orphan <= 1'b1;
            end
        end
    end

    assign err_orphan   = r_err_orphan;
    assign dbg_ar_state = r_state;
    assign dbg_last_gnt = w_last_gnt;
    assign dbg_outst0   = r_outst0;
    assign dbg_outst1   = r_outst1;

endmodule

// File: tb/tb_eva_axi_rd_arb.sv
// Directed bench for eva_axi_rd_arb: per-master AR drivers, a slave-side AR
// scoreboard with an expected queue, and direct checks on R routing/counters.
module tb_eva_axi_rd_arb;

    typedef struct packed {
        logic [2:0]  id;
        logic [31:0] addr;
        logic [5:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } req_t;

    logic         aclk = 1'b0;
    logic         arest_n = 1'b0;

    logic         m0_arvalid, m0_arready, m1_arvalid, m1_arready;
    logic [2:0]   m0_arid, m1_arid;
    logic [31:0]  m0_araddr, m1_araddr;
    logic [5:0]   m0_arlen, m1_arlen;
    logic [2:0]   m0_arsize, m1_arsize;
    logic [1:0]   m0_arburst, m1_arburst;
    logic         m0_rvalid, m0_rlast, m1_rvalid, m1_rlast;
    logic [2:0]   m0_rid, m1_rid;
    logic [127:0] m0_rdata, m1_rdata;
    logic [1:0]   m0_rresp, m1_rresp;
    logic         m0_rready, m1_rready;
    logic         s_arvalid, s_arready;
    logic [3:0]   s_arid;
    logic [31:0]  s_araddr;
    logic [5:0]   s_arlen;
    logic [2:0]   s_arsize;
    logic [1:0]   s_arburst;
    logic         s_rvalid, s_rready, s_rlast;
    logic [3:0]   s_rid;
    logic [127:0] s_rdata;
    logic [1:0]   s_rresp;
    logic         err_orphan;
    logic         dbg_ar_state, dbg_last_gnt;
    logic [2:0]   dbg_outst0, dbg_outst1;

    req_t         m0_q[$];
    req_t         m1_q[$];
    logic [46:0]  exp_q[$];
    int           hs_cyc[$];
    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    logic [46:0]  mon_got;
    logic [46:0]  mon_exp;

    eva_axi_rd_arb #(.MAX_OUTST(4)) dut (
        .aclk(aclk), .arest_n(arest_n),
        .m0_arvalid(m0_arvalid), .m0_arready(m0_arready), .m0_arid(m0_arid),
        .m0_araddr(m0_araddr), .m0_arlen(m0_arlen), .m0_arsize(m0_arsize),
        .m0_arburst(m0_arburst), .m0_rvalid(m0_rvalid), .m0_rlast(m0_rlast),
        .m0_rid(m0_rid), .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rready(m0_rready),
        .m1_arvalid(m1_arvalid), .m1_arready(m1_arready), .m1_arid(m1_arid),
        .m1_araddr(m1_araddr), .m1_arlen(m1_arlen), .m1_arsize(m1_arsize),
        .m1_arburst(m1_arburst), .m1_rvalid(m1_rvalid), .m1_rlast(m1_rlast),
        .m1_rid(m1_rid), .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rready(m1_rready),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_arid(s_arid), .s_araddr(s_araddr),
        .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rlast(s_rlast), .s_rid(s_rid),
        .s_rdata(s_rdata), .s_rresp(s_rresp),
        .err_orphan(err_orphan),
        .dbg_ar_state(dbg_ar_state), .dbg_last_gnt(dbg_last_gnt),
        .dbg_outst0(dbg_outst0), .dbg_outst1(dbg_outst1)
    );

    // ---------------- clock / reset ----------------
    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic req_t mk_req(input int id, input logic [31:0] addr, input int len);
        req_t r;
        r.id    = id[2:0];
        r.addr  = addr;
        r.len   = len[5:0];
        r.size  = 3'd4;
        r.burst = 2'b01;
        return r;
    endfunction

    function automatic logic [46:0] mk_exp(input logic m, input req_t r);
        return {m, r};
    endfunction

    // One R beat presented for a single cycle.
    task automatic r_beat(input logic [3:0] rid, input logic last, input logic [127:0] data);
        @(posedge aclk); #1;
        s_rvalid = 1'b1; s_rid = rid; s_rlast = last; s_rdata = data; s_rresp = 2'b00;
        @(posedge aclk); #1;
        s_rvalid = 1'b0; s_rlast = 1'b0;
    endtask

    task automatic wait_drain(input string name, input bit masters_too, input int budget);
        int n;
        n = 0;
        while (((exp_q.size() != 0) || (masters_too && ((m0_q.size() != 0) || (m1_q.size() != 0))))
               && (n < budget)) begin
            @(negedge aclk);
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL %s_timeout: exp_q left %0d expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    // ---------------- master AR drivers ----------------
    initial begin
        m0_arvalid = 1'b0;
        {m0_arid, m0_araddr, m0_arlen, m0_arsize, m0_arburst} = '0;
        forever begin
            @(negedge aclk);
            if (m0_arvalid && m0_arready) void'(m0_q.pop_front());
            @(posedge aclk); #1;
            if (m0_q.size() != 0) begin
                m0_arvalid = 1'b1;
                {m0_arid, m0_araddr, m0_arlen, m0_arsize, m0_arburst} = m0_q[0];
            end else begin
                m0_arvalid = 1'b0;
            end
        end
    end

    initial begin
        m1_arvalid = 1'b0;
        {m1_arid, m1_araddr, m1_arlen, m1_arsize, m1_arburst} = '0;
        forever begin
            @(negedge aclk);
            if (m1_arvalid && m1_arready) void'(m1_q.pop_front());
            @(posedge aclk); #1;
            if (m1_q.size() != 0) begin
                m1_arvalid = 1'b1;
                {m1_arid, m1_araddr, m1_arlen, m1_arsize, m1_arburst} = m1_q[0];
            end else begin
                m1_arvalid = 1'b0;
            end
        end
    end

    // ---------------- slave-side AR monitor / scoreboard ----------------
    always @(negedge aclk) begin
        if (arest_n && s_arvalid && s_arready) begin
            mon_got = {s_arid, s_araddr, s_arlen, s_arsize, s_arburst};
            hs_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL ar_unexpected: got 0x%0h expected none", mon_got);
            end else begin
                mon_exp = exp_q.pop_front();
                check("ar_payload", 128'(mon_got), 128'(mon_exp));
            end
        end
    end

    // ---------------- directed sequence ----------------
    req_t r;
    logic [31:0] held_addr;
    bit          seen;
    localparam logic [127:0] DATA_A = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

    initial begin
        s_arready = 1'b0;
        s_rvalid  = 1'b0; s_rlast = 1'b0; s_rid = '0; s_rdata = '0; s_rresp = '0;
        m0_rready = 1'b1; m1_rready = 1'b1;

        // Reset state, with the first m0 request already waiting.
        r = mk_req(5, 32'h0000_1000, 3);
        m0_q.push_back(r);
        exp_q.push_back(mk_exp(1'b0, r));
        s_arready = 1'b1;
        repeat (2) @(negedge aclk);
        check("rst_m0_arready", m0_arready, 0);
        check("rst_s_arvalid", s_arvalid, 0);
        check("rst_s_arid", s_arid, 0);
        check("rst_s_araddr", s_araddr, 0);
        check("rst_s_arlen", s_arlen, 0);
        check("rst_err_orphan", err_orphan, 0);
        check("rst_state", dbg_ar_state, 0);
        check("rst_outst0", dbg_outst0, 0);
        check("rst_outst1", dbg_outst1, 0);

        // Single m0 request: arready in cycle 0, s_arvalid with id 5 in cycle 1.
        @(posedge aclk); #1;
        arest_n = 1'b1;
        @(negedge aclk);
        check("t1_m0_arready_c0", m0_arready, 1);
        check("t1_m1_arready_c0", m1_arready, 0);
        check("t1_s_arvalid_c0", s_arvalid, 0);
        @(negedge aclk);
        check("t1_s_arvalid_c1", s_arvalid, 1);
        check("t1_s_arid_c1", s_arid, 4'h5);
        check("t1_m0_arready_c1", m0_arready, 0);
        @(negedge aclk);
        check("t1_s_arvalid_c2", s_arvalid, 0);
        check("t1_outst0", dbg_outst0, 1);
        r_beat(4'h5, 1'b1, DATA_A);
        @(negedge aclk);
        check("t1_outst0_retired", dbg_outst0, 0);

        // Both masters busy: last grant was m0, so m1 leads and they alternate.
        @(negedge aclk);
        hs_cyc.delete();
        for (int i = 0; i < 3; i++) begin
            m0_q.push_back(mk_req(i, 32'h0000_2000 + 32'(i * 64), 1));
            m1_q.push_back(mk_req(4 + i, 32'h0000_8000 + 32'(i * 64), 2));
        end
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(mk_exp(1'b1, m1_q[i]));
            exp_q.push_back(mk_exp(1'b0, m0_q[i]));
        end
        wait_drain("t2_drain", 1'b1, 40);
        check("t2_hs_count", hs_cyc.size(), 6);
        for (int i = 1; i < hs_cyc.size(); i++) begin
            check("t2_hs_spacing", hs_cyc[i] - hs_cyc[i-1], 2);
        end
        check("t2_outst0", dbg_outst0, 3);
        check("t2_outst1", dbg_outst1, 3);
        for (int i = 0; i < 3; i++) begin
            r_beat({1'b0, 3'(i)}, 1'b1, DATA_A);
            r_beat({1'b1, 3'(4 + i)}, 1'b1, DATA_A);
        end
        @(negedge aclk);
        check("t2_outst0_retired", dbg_outst0, 0);
        check("t2_outst1_retired", dbg_outst1, 0);
        check("t2_no_orphan", err_orphan, 0);

        // m0 fills its limit; its fifth request waits while m1 is served.
        @(negedge aclk);
        for (int i = 0; i < 4; i++) begin
            r = mk_req(i, 32'h0000_3000 + 32'(i * 16), 0);
            m0_q.push_back(r);
            exp_q.push_back(mk_exp(1'b0, r));
        end
        wait_drain("t3_fill", 1'b1, 40);
        check("t3_outst0_full", dbg_outst0, 4);
        @(negedge aclk);
        m0_q.push_back(mk_req(7, 32'h0000_3FF0, 5));
        r = mk_req(1, 32'h0000_9000, 4);
        m1_q.push_back(r);
        exp_q.push_back(mk_exp(1'b1, r));
        wait_drain("t3_m1_pass", 1'b0, 20);
        for (int i = 0; i < 4; i++) begin
            @(negedge aclk);
            check("t3_m0_stalled", m0_arready, 0);
        end
        check("t3_m0_still_valid", m0_arvalid, 1);
        check("t3_m0_pending", m0_q.size(), 1);
        check("t3_outst0_hold", dbg_outst0, 4);
        exp_q.push_back(mk_exp(1'b0, mk_req(7, 32'h0000_3FF0, 5)));
        r_beat(4'h0, 1'b1, DATA_A);
        wait_drain("t3_m0_resume", 1'b1, 20);
        check("t3_outst0_after", dbg_outst0, 4);
        check("t3_outst1_after", dbg_outst1, 1);

        // R routing by s_rid[3], with m1 back-pressuring.
        @(posedge aclk); #1;
        m0_rready = 1'b1; m1_rready = 1'b0;
        s_rvalid = 1'b1; s_rid = 4'hA; s_rlast = 1'b0; s_rdata = DATA_A; s_rresp = 2'b10;
        @(negedge aclk);
        check("t4_m1_rvalid", m1_rvalid, 1);
        check("t4_m1_rid", m1_rid, 2);
        check("t4_m0_rvalid", m0_rvalid, 0);
        check("t4_s_rready", s_rready, 0);
        check("t4_m0_rdata", m0_rdata, DATA_A);
        check("t4_m1_rdata", m1_rdata, DATA_A);
        check("t4_m0_rresp", m0_rresp, 2'b10);
        @(posedge aclk); #1;
        m1_rready = 1'b1; s_rlast = 1'b1;
        @(negedge aclk);
        check("t4_s_rready_m1", s_rready, 1);
        check("t4_m0_rlast", m0_rlast, 1);
        @(posedge aclk); #1;
        s_rid = 4'h3; s_rlast = 1'b0; m0_rready = 1'b0;
        @(negedge aclk);
        check("t4_m0_rvalid_sel", m0_rvalid, 1);
        check("t4_m1_rvalid_sel", m1_rvalid, 0);
        check("t4_s_rready_m0", s_rready, 0);
        @(posedge aclk); #1;
        s_rvalid = 1'b0; m0_rready = 1'b1;
        @(negedge aclk);
        check("t4_outst1_retired", dbg_outst1, 0);
        check("t4_outst0_kept", dbg_outst0, 4);
        for (int i = 0; i < 4; i++) r_beat(4'h1, 1'b1, DATA_A);
        @(negedge aclk);
        check("t4_outst0_empty", dbg_outst0, 0);
        check("t4_no_orphan", err_orphan, 0);

        // Orphan rlast for m0 sets the sticky flag without underflow.
        r_beat(4'h3, 1'b1, DATA_A);
        @(negedge aclk);
        check("t5_err_orphan", err_orphan, 1);
        check("t5_outst0_zero", dbg_outst0, 0);
        check("t5_outst1_zero", dbg_outst1, 0);
        r_beat(4'h3, 1'b0, DATA_A);
        repeat (3) @(negedge aclk);
        check("t5_err_orphan_sticky", err_orphan, 1);

        // Reset while an m0 request sits in ISSUE with the slave stalled.
        s_arready = 1'b0;
        @(negedge aclk);
        m0_q.push_back(mk_req(6, 32'h0000_ABC0, 7));
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge aclk);
            seen = s_arvalid;
        end
        check("t6_issue_seen", seen, 1);
        check("t6_s_arid", s_arid, 4'h6);
        held_addr = s_araddr;
        repeat (2) begin
            @(negedge aclk);
            check("t6_hold_valid", s_arvalid, 1);
            check("t6_hold_addr", s_araddr, 32'h0000_ABC0);
            check("t6_issue_m0_arready", m0_arready, 0);
        end
        @(posedge aclk); #2;
        arest_n = 1'b0;
        #1;
        check("t6_async_drop", s_arvalid, 0);
        check("t6_rst_state", dbg_ar_state, 0);
        check("t6_rst_outst0", dbg_outst0, 0);
        check("t6_rst_orphan", err_orphan, 0);
        s_rvalid = 1'b1; s_rid = 4'h1; m0_rready = 1'b1; m1_rready = 1'b0;
        #1;
        check("t6_rst_m0_rvalid", m0_rvalid, 1);
        check("t6_rst_s_rready", s_rready, 1);
        s_rvalid = 1'b0;
        @(posedge aclk); #1;
        arest_n = 1'b1; s_arready = 1'b1; m1_rready = 1'b1;
        @(negedge aclk);
        check("t6_post_outst0", dbg_outst0, 0);
        check("t6_post_outst1", dbg_outst1, 0);
        check("t6_post_s_arvalid", s_arvalid, 0);
        check("t6_post_held_addr_gone", s_araddr == held_addr, 0);
        r = mk_req(2, 32'h0000_5000, 1);
        m0_q.push_back(r);
        exp_q.push_back(mk_exp(1'b0, r));
        r = mk_req(3, 32'h0000_6000, 1);
        m1_q.push_back(r);
        exp_q.push_back(mk_exp(1'b1, r));
        wait_drain("t6_first_tie", 1'b1, 20);

        repeat (2) @(negedge aclk);
        check("end_exp_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/eva_axi_rd_arb.md
EVA_AXI_RD_ARB -- requirements
Module: eva_axi_rd_arb

Interface
REQ-001 SHALL have parameter MAX_OUTST, default 4, meaning the maximum number of outstanding read bursts per master (legal range 1..7).
REQ-002 SHALL have port aclk  input  1  single clock; all logic on its rising edge.
REQ-003 SHALL have port arest_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have ports m0_arvalid/m1_arvalid  input  1  master read-address valid.
REQ-005 SHALL have ports m0_arready/m1_arready  output  1  master read-address accept.
REQ-006 SHALL have ports m0_arid/m1_arid  input  3  master transaction ID.
REQ-007 SHALL have ports m0_araddr/m1_araddr  input  32  master address.
REQ-008 SHALL have ports m0_arlen/m1_arlen  input  6, m0_arsize/m1_arsize  input  3, and m0_arburst/m1_arburst  input  2, each carrying burst attributes.
REQ-009 SHALL have ports m0_rvalid/m1_rvalid, m0_rlast/m1_rlast  output  1, m0_rid/m1_rid  output  3, m0_rdata/m1_rdata  output  128, and m0_rresp/m1_rresp  output  2, together forming the routed read-data channel.
REQ-010 SHALL have ports m0_rready/m1_rready  input  1  master read-data accept.
REQ-011 SHALL have ports s_arvalid  output  1, s_arid  output  4, s_araddr  output  32, s_arlen  output  6, s_arsize  output  3, and s_arburst  output  2, forming the slave address channel.
REQ-012 SHALL have port s_arready  input  1  slave address accept.
REQ-013 SHALL have ports s_rvalid, s_rlast  input  1, s_rid  input  4, s_rdata  input  128, and s_rresp  input  2, forming the slave read-data channel.
REQ-014 SHALL have port s_rready  output  1  slave read-data accept.
REQ-015 SHALL have port err_orphan  output  1, a sticky flag set when read data returns for a master with zero outstanding bursts.

Function
REQ-016 SHALL implement AR state machine IDLE -> ISSUE -> IDLE; IDLE selects a winner, ISSUE holds s_ar* registered until s_arvalid&&s_arready.
REQ-017 In IDLE a master SHALL be eligible when mX_arvalid=1 and outst_X < MAX_OUTST.
REQ-018 Arbitration SHALL be round-robin: the master not granted last wins ties, and a sole eligible master always wins.
REQ-019 On a grant in IDLE, the block SHALL pulse mX_arready for exactly that cycle, register the payload into s_ar*, set s_arid={X,mX_arid}, and enter ISSUE; s_arvalid SHALL rise the next cycle (1-cycle latency).
REQ-020 In ISSUE, s_ar* SHALL stay stable and both mX_arready SHALL be 0; on the s_arready handshake the block SHALL return to IDLE, and a new grant SHALL be possible in the following cycle (peak throughput one AR per 2 cycles).
REQ-021 The last-grant pointer SHALL update only on a grant.
REQ-022 outst_X SHALL be a 3-bit counter that increments on mX_arready, decrements on an s_r handshake with s_rlast=1 and s_rid[3]==X, and holds its value on a simultaneous increment and decrement.
REQ-023 R routing SHALL be combinational with zero latency: mX_rvalid = s_rvalid && (s_rid[3]==X); mX_rid = s_rid[2:0]; rdata/rresp/rlast SHALL be fanned out to both masters; s_rready = s_rid[3] ? m1_rready : m0_rready.
REQ-024 An s_r handshake with rlast=1 for a master whose outst_X=0 SHALL set err_orphan, and the counter SHALL NOT underflow (stays 0).
REQ-025 No counter SHALL exceed MAX_OUTST; a master at the limit SHALL be skipped while the other proceeds.

Reset
REQ-026 On arest_n=0, the block SHALL enter state IDLE, and s_arvalid, s_arid, s_araddr, s_arlen, s_arsize, s_arburst, mX_arready, outst_X and err_orphan SHALL all be 0, with the pointer set so that m0 wins the first tie.
REQ-027 Reset mid-ISSUE SHALL drop s_arvalid immediately (asynchronously), and the pending request SHALL be discarded.
REQ-028 Routed R outputs SHALL follow s_r inputs during reset; s_rready SHALL follow the selected mX_rready.

Structure
REQ-029 Package eva_axi_pkg SHALL hold the width constants (ID 4, DATA 128, LEN 6) and the AR state enum.
REQ-030 The design SHALL include one sub-module, eva_rr_arb2, implementing the 2-way round-robin pick plus pointer.

Verification
REQ-031 Only m0 requests araddr 0x1000, arid 5 -> m0_arready pulses in cycle 0, s_arvalid=1 with s_arid=0x5 in cycle 1.
REQ-032 m0 and m1 request continuously with s_arready=1 -> grants alternate m0,m1,m0,m1, one every 2 cycles.
REQ-033 m0 issues 4 ARs with no R returned (MAX_OUTST=4) -> 5th m0 request stalls while m1 is still granted; one rlast for m0 -> m0 is granted again.
REQ-034 s_rid=0xA, s_rvalid=1, m1_rready=0 -> m1_rvalid=1, m1_rid=2, m0_rvalid=0, s_rready=0.
REQ-035 s_rlast handshake with s_rid[3]=0 while outst_0=0 -> err_orphan=1 (sticky) and outst_0 stays 0.
REQ-036 arest_n asserted during ISSUE with s_arready=0 -> s_arvalid=0 at once; after release, outst counters are 0 and m0 wins the first tie.
